// File: rtl/control_sequencer.sv
// Microsequencer for the accumulator computer: walks fetch, decode and execute and emits every
// datapath write enable, mux select, ALU opcode and memory strobe as a Moore decode of state.
module control_sequencer #(
   parameter int unsigned MEM_LATENCY = 1,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       ir_opcode,
   input  logic             acc_zero,
   input  logic             acc_neg,
   output logic             pc_write,
   output logic             pc_src,
   output logic             mar_write,
   output logic             mar_src,
   output logic             mbr_write,
   output logic             mbr_src,
   output logic             ir_write,
   output logic             acc_write,
   output logic             acc_src,
   output logic [3:0]       alu_op,
   output logic             mem_write,
   output logic             halted,
   output logic             illegal,
   output logic [3:0]       state_out,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      StIdle   = 4'd0,
      StFMar   = 4'd1,
      StFRead  = 4'd2,
      StFMbr   = 4'd3,
      StFIr    = 4'd4,
      StDecode = 4'd5,
      StEMar   = 4'd6,
      StERead  = 4'd7,
      StEMbr   = 4'd8,
      StEAcc   = 4'd9,
      StEStMbr = 4'd10,
      StEWrite = 4'd11,
      StEJmp   = 4'd12,
      StHalted = 4'd13
   } state_e;

   localparam logic [3:0] OpNop   = 4'h0;
   localparam logic [3:0] OpLoad  = 4'h1;
   localparam logic [3:0] OpStore = 4'h2;
   localparam logic [3:0] OpAdd   = 4'h3;
   localparam logic [3:0] OpSub   = 4'h4;
   localparam logic [3:0] OpAnd   = 4'h5;
   localparam logic [3:0] OpOr    = 4'h6;
   localparam logic [3:0] OpXor   = 4'h7;
   localparam logic [3:0] OpShl   = 4'h8;
   localparam logic [3:0] OpShr   = 4'h9;
   localparam logic [3:0] OpJump  = 4'hA;
   localparam logic [3:0] OpJumpz = 4'hB;
   localparam logic [3:0] OpJumpn = 4'hC;
   localparam logic [3:0] OpMul   = 4'hD;
   localparam logic [3:0] OpIll   = 4'hE;
   localparam logic [3:0] OpHalt  = 4'hF;

   localparam int unsigned WaitW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

   state_e             state_q, state_d;
   logic [WaitW-1:0]   wait_q, wait_d;
   logic               halted_q, halted_d;
   logic               illegal_q, illegal_d;
   logic [CNT_W-1:0]   count_q;
   logic               count_inc;
   logic               wait_last;

   assign wait_last = (wait_q == WaitW'(MEM_LATENCY - 1));

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      halted_d  = halted_q;
      illegal_d = illegal_q;
      unique case (state_q)
         StIdle:   if (start) state_d = StFMar;
         StFMar:   state_d = StFRead;
         StFRead: begin
            if (wait_last) begin
               wait_d  = '0;
               state_d = StFMbr;
            end else begin
               wait_d = wait_q + WaitW'(1);
            end
         end
         StFMbr:   state_d = StFIr;
         StFIr:    state_d = StDecode;
         StDecode: begin
            case (ir_opcode)
               OpLoad, OpStore, OpAdd, OpSub, OpAnd, OpOr, OpXor, OpMul: state_d = StEMar;
               OpShl, OpShr: state_d = StEAcc;
               OpJump:       state_d = StEJmp;
               OpJumpz:      state_d = acc_zero ? StEJmp : StFMar;
               OpJumpn:      state_d = acc_neg ? StEJmp : StFMar;
               OpHalt: begin
                  state_d  = StHalted;
                  halted_d = 1'b1;
               end
               OpIll: begin
                  state_d   = StHalted;
                  halted_d  = 1'b1;
                  illegal_d = 1'b1;
               end
               default:      state_d = StFMar;
            endcase
         end
         StEMar:   state_d = (ir_opcode == OpStore) ? StEStMbr : StERead;
         StERead: begin
            if (wait_last) begin
               wait_d  = '0;
               state_d = StEMbr;
            end else begin
               wait_d = wait_q + WaitW'(1);
            end
         end
         StEMbr:   state_d = StEAcc;
         StEAcc:   state_d = StFMar;
         StEStMbr: state_d = StEWrite;
         StEWrite: state_d = StFMar;
         StEJmp:   state_d = StFMar;
         StHalted: state_d = StHalted;
         default:  state_d = StIdle;
      endcase
   end

   // A retirement is the return to fetch, or HALT itself; the illegal opcode never retires.
   assign count_inc = ((state_d == StFMar) && (state_q != StIdle)) ||
                      ((state_q == StDecode) && (ir_opcode == OpHalt));

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= StIdle;
         wait_q    <= '0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
         if (count_inc) count_q <= count_q + CNT_W'(1);
      end
   end

   // Gated by reset so a write caught mid-instruction is dropped before the reset edge.
   always_comb begin
      pc_write  = 1'b0;
      pc_src    = 1'b0;
      mar_write = 1'b0;
      mar_src   = 1'b0;
      mbr_write = 1'b0;
      mbr_src   = 1'b0;
      ir_write  = 1'b0;
      acc_write = 1'b0;
      acc_src   = 1'b0;
      alu_op    = 4'b0000;
      mem_write = 1'b0;
      if (!reset) begin
         unique case (state_q)
            StFMar:   mar_write = 1'b1;
            StFMbr:   mbr_write = 1'b1;
            StFIr: begin
               ir_write = 1'b1;
               pc_write = 1'b1;
            end
            StEMar: begin
               mar_write = 1'b1;
               mar_src   = 1'b1;
            end
            StEMbr:   mbr_write = 1'b1;
            StEAcc: begin
               acc_write = 1'b1;
               acc_src   = (ir_opcode == OpLoad);
               case (ir_opcode)
                  OpSub:   alu_op = 4'b0001;
                  OpMul:   alu_op = 4'b0010;
                  OpShl:   alu_op = 4'b0100;
                  OpShr:   alu_op = 4'b0101;
                  OpAnd:   alu_op = 4'b1000;
                  OpOr:    alu_op = 4'b1001;
                  OpXor:   alu_op = 4'b1010;
                  default: alu_op = 4'b0000;
               endcase
            end
            StEStMbr: begin
               mbr_write = 1'b1;
               mbr_src   = 1'b1;
            end
            StEWrite: mem_write = 1'b1;
            StEJmp: begin
               pc_write = 1'b1;
               pc_src   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign halted      = halted_q;
   assign illegal     = illegal_q;
   assign state_out   = state_q;
   assign instr_count = count_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench: a small datapath driven by the sequencer, plus an instruction-level model that expands
// each instruction into its expected per-cycle control vector.
module tb_control_sequencer;
   localparam int unsigned L = 1;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset, start, start3;
   logic [3:0]  ir_opcode;
   logic        acc_zero, acc_neg;
   logic        pc_write, pc_src, mar_write, mar_src, mbr_write, mbr_src, ir_write;
   logic        acc_write, acc_src, mem_write, halted, illegal;
   logic [3:0]  alu_op, state_out;
   logic [15:0] instr_count;

   logic        pc_write3, pc_src3, mar_write3, mar_src3, mbr_write3, mbr_src3, ir_write3;
   logic        acc_write3, acc_src3, mem_write3, halted3, illegal3;
   logic [3:0]  alu_op3, state_out3;
   logic [15:0] instr_count3;

   control_sequencer #(.MEM_LATENCY(L), .CNT_W(16)) dut (
      .clock(clock), .reset(reset), .start(start), .ir_opcode(ir_opcode),
      .acc_zero(acc_zero), .acc_neg(acc_neg), .pc_write(pc_write), .pc_src(pc_src),
      .mar_write(mar_write), .mar_src(mar_src), .mbr_write(mbr_write), .mbr_src(mbr_src),
      .ir_write(ir_write), .acc_write(acc_write), .acc_src(acc_src), .alu_op(alu_op),
      .mem_write(mem_write), .halted(halted), .illegal(illegal), .state_out(state_out),
      .instr_count(instr_count)
   );

   // Latency-3 instance with a constant LOAD opcode, used only for cycle timing.
   control_sequencer #(.MEM_LATENCY(3), .CNT_W(16)) dut3 (
      .clock(clock), .reset(reset), .start(start3), .ir_opcode(4'h1),
      .acc_zero(1'b0), .acc_neg(1'b0), .pc_write(pc_write3), .pc_src(pc_src3),
      .mar_write(mar_write3), .mar_src(mar_src3), .mbr_write(mbr_write3), .mbr_src(mbr_src3),
      .ir_write(ir_write3), .acc_write(acc_write3), .acc_src(acc_src3), .alu_op(alu_op3),
      .mem_write(mem_write3), .halted(halted3), .illegal(illegal3), .state_out(state_out3),
      .instr_count(instr_count3)
   );

   // ---------------- datapath driven by the DUT ----------------
   logic [15:0] dmem [4096];
   logic [15:0] acc, mbr, ir;
   logic [11:0] pc, mar;
   logic [11:0] fetch_log [$];
   logic        ld_en, set_en;
   logic [11:0] ld_addr, set_pc;
   logic [15:0] ld_data, set_acc;

   assign ir_opcode = ir[15:12];
   assign acc_zero  = (acc == 16'h0);
   assign acc_neg   = acc[15];

   function automatic logic [15:0] alu_eval(input logic [3:0] code, input logic [15:0] a,
                                            input logic [15:0] b);
      case (code)
         4'b0000: return a + b;
         4'b0001: return a - b;
         4'b0010: return a * b;
         4'b0100: return a << 1;
         4'b0101: return a >> 1;
         4'b1000: return a & b;
         4'b1001: return a | b;
         4'b1010: return a ^ b;
         default: return a;
      endcase
   endfunction

   always @(posedge clock) begin
      if (ld_en) dmem[ld_addr] <= ld_data;
      if (set_en) begin
         pc  <= set_pc;
         acc <= set_acc;
         ir  <= 16'h0;
      end else begin
         if (mem_write) dmem[mar] <= mbr;
         if (mar_write) begin
            mar <= mar_src ? ir[11:0] : pc;
            if (!mar_src) fetch_log.push_back(pc);
         end
         if (mbr_write) mbr <= mbr_src ? acc : dmem[mar];
         if (ir_write)  ir  <= mbr;
         if (pc_write)  pc  <= pc_src ? ir[11:0] : pc + 12'd1;
         if (acc_write) acc <= acc_src ? mbr : alu_eval(alu_op, acc, mbr);
      end
   end

   // ---------------- instruction-level reference model ----------------
   typedef struct packed {
      logic [8:0]  ctl;   // pc_write pc_src mar_write mar_src mbr_write mbr_src ir_write acc_write acc_src
      logic [3:0]  alu_op;
      logic        mem_write;
      logic        halted;
      logic        illegal;
      logic [15:0] cnt;
   } vec_t;

   localparam logic [8:0] CNone   = 9'b000000000;
   localparam logic [8:0] CFMar   = 9'b001000000;
   localparam logic [8:0] CMbr    = 9'b000010000;
   localparam logic [8:0] CFIr    = 9'b100000100;
   localparam logic [8:0] CEMar   = 9'b001100000;
   localparam logic [8:0] CStMbr  = 9'b000011000;
   localparam logic [8:0] CJmp    = 9'b110000000;
   localparam logic [8:0] CAccAlu = 9'b000000010;
   localparam logic [8:0] CAccMbr = 9'b000000011;

   logic [15:0] mmem [4096];
   logic [15:0] m_acc, m_cnt;
   logic [11:0] m_pc;
   logic        m_halt, m_ill, m_first;
   vec_t        exp_q [$];
   bit          checking;
   int          n_cmp, n_bad, n_step;

   function automatic vec_t mk(input logic [8:0] c, input logic [3:0] op, input logic mw);
      vec_t v;
      v = {c, op, mw, m_halt, m_ill, m_cnt};
      return v;
   endfunction

   function automatic vec_t dut_vec();
      vec_t v;
      v = {pc_write, pc_src, mar_write, mar_src, mbr_write, mbr_src, ir_write, acc_write,
           acc_src, alu_op, mem_write, halted, illegal, instr_count};
      return v;
   endfunction

   function automatic logic [3:0] alu_code(input logic [3:0] op);
      case (op)
         4'h4:    return 4'b0001;
         4'hD:    return 4'b0010;
         4'h8:    return 4'b0100;
         4'h9:    return 4'b0101;
         4'h5:    return 4'b1000;
         4'h6:    return 4'b1001;
         4'h7:    return 4'b1010;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [15:0] isa_result(input logic [3:0] op, input logic [15:0] a,
                                              input logic [15:0] m);
      case (op)
         4'h1:    return m;
         4'h3:    return a + m;
         4'h4:    return a - m;
         4'h5:    return a & m;
         4'h6:    return a | m;
         4'h7:    return a ^ m;
         4'h8:    return {a[14:0], 1'b0};
         4'h9:    return {1'b0, a[15:1]};
         4'hD:    return a * m;
         default: return a;
      endcase
   endfunction

   task automatic push_none(input int n);
      repeat (n) exp_q.push_back(mk(CNone, 4'h0, 1'b0));
   endtask

   task automatic model_step();
      logic [15:0] w;
      logic [3:0]  op;
      logic [11:0] a;
      logic        taken;
      if (m_halt) begin
         push_none(1);
         return;
      end
      if (!m_first) m_cnt = m_cnt + 16'd1;
      m_first = 1'b0;
      exp_q.push_back(mk(CFMar, 4'h0, 1'b0));
      push_none(L);
      exp_q.push_back(mk(CMbr, 4'h0, 1'b0));
      exp_q.push_back(mk(CFIr, 4'h0, 1'b0));
      push_none(1);
      w    = mmem[m_pc];
      m_pc = m_pc + 12'd1;
      op   = w[15:12];
      a    = w[11:0];
      case (op)
         4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hD: begin
            exp_q.push_back(mk(CEMar, 4'h0, 1'b0));
            push_none(L);
            exp_q.push_back(mk(CMbr, 4'h0, 1'b0));
            exp_q.push_back(mk((op == 4'h1) ? CAccMbr : CAccAlu, alu_code(op), 1'b0));
            m_acc = isa_result(op, m_acc, mmem[a]);
         end
         4'h2: begin
            exp_q.push_back(mk(CEMar, 4'h0, 1'b0));
            exp_q.push_back(mk(CStMbr, 4'h0, 1'b0));
            exp_q.push_back(mk(CNone, 4'h0, 1'b1));
            mmem[a] = m_acc;
         end
         4'h8, 4'h9: begin
            exp_q.push_back(mk(CAccAlu, alu_code(op), 1'b0));
            m_acc = isa_result(op, m_acc, 16'h0);
         end
         4'hA, 4'hB, 4'hC: begin
            taken = (op == 4'hA) || (op == 4'hB && m_acc == 16'h0) || (op == 4'hC && m_acc[15]);
            if (taken) begin
               exp_q.push_back(mk(CJmp, 4'h0, 1'b0));
               m_pc = a;
            end
         end
         4'hF: begin
            m_cnt  = m_cnt + 16'd1;
            m_halt = 1'b1;
            push_none(1);
         end
         4'hE: begin
            m_halt = 1'b1;
            m_ill  = 1'b1;
            push_none(1);
         end
         default: ;
      endcase
   endtask

   // ---------------- checking ----------------
   task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, got, want);
      end
   endtask

   task automatic compare_loop();
      vec_t e, g;
      forever begin
         @(negedge clock);
         if (checking && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = dut_vec();
            n_cmp++;
            n_step++;
            if (g !== e) begin
               n_bad++;
               $display("FAIL cycle-vector step %0d: got %h, required %h", n_step, g, e);
            end
         end
      end
   endtask

   // ---------------- sequencing helpers ----------------
   task automatic load(input logic [11:0] addr, input logic [15:0] data);
      ld_en = 1'b1; ld_addr = addr; ld_data = data;
      @(posedge clock); #1;
      ld_en = 1'b0;
      mmem[addr] = data;
   endtask

   task automatic begin_scenario(input logic [15:0] acc0);
      @(posedge clock); #1;
      reset = 1'b1; checking = 1'b0; start = 1'b0;
      exp_q.delete();
      m_cnt = 16'h0; m_halt = 1'b0; m_ill = 1'b0; m_first = 1'b1; m_pc = 12'h0; m_acc = acc0;
      set_en = 1'b1; set_pc = 12'h0; set_acc = acc0;
      @(posedge clock); #1;
      set_en = 1'b0;
   endtask

   task automatic start_run();
      @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock); #1;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      checking = 1'b1;
   endtask

   int first_ld, cnt_after_ld, jumps;

   task automatic run_trace();
      int cyc;
      cyc = 1; first_ld = -1; cnt_after_ld = -1; jumps = 0;
      while (exp_q.size() > 0 && cyc < 5000) begin
         if (first_ld > 0 && cyc == first_ld + 1) cnt_after_ld = int'(instr_count);
         if (acc_write && acc_src && first_ld < 0) first_ld = cyc;
         if (pc_write && pc_src) jumps++;
         @(posedge clock); #1;
         cyc++;
      end
      check_lit("trace-drained", exp_q.size(), 0);
   endtask

   initial begin
      int base, g, cyc3, first3, diff;
      int mar_c [$];
      int mbr_c [$];
      logic [11:0] fexp [8];
      logic [3:0]  rop;
      logic [11:0] ad;
      reset = 1'b1; start = 1'b0; start3 = 1'b0; ld_en = 1'b0; set_en = 1'b0;
      ld_addr = '0; ld_data = '0; set_pc = '0; set_acc = '0; checking = 1'b0;
      n_cmp = 0; n_bad = 0; n_step = 0;
      m_cnt = 0; m_halt = 0; m_ill = 0; m_first = 1; m_pc = 0; m_acc = 0;
      fork compare_loop(); join_none
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;

      // Latency 3: reads held three cycles, LOAD completes in 13 cycles.
      @(posedge clock); #1 start3 = 1'b1;
      @(posedge clock); #1 start3 = 1'b0;
      cyc3 = 1; first3 = -1;
      while (cyc3 <= 16) begin
         if (mar_write3) mar_c.push_back(cyc3);
         if (mbr_write3) mbr_c.push_back(cyc3);
         if (acc_write3 && acc_src3 && first3 < 0) first3 = cyc3;
         @(posedge clock); #1;
         cyc3++;
      end
      check_lit("l3-load-cycles", first3, 13);
      check_lit("l3-mar-writes", mar_c.size(), 3);
      check_lit("l3-mbr-writes", mbr_c.size(), 2);
      if (mar_c.size() >= 2 && mbr_c.size() >= 2) begin
         check_lit("l3-f-read-len", mbr_c[0] - mar_c[0] - 1, 3);
         check_lit("l3-e-read-len", mbr_c[1] - mar_c[1] - 1, 3);
      end

      // Directed program: LOAD, ADD, STORE, SUB, JUMPZ taken, LOAD, JUMPZ untaken, HALT.
      begin_scenario(16'h0);
      load(12'h000, 16'h1010); load(12'h001, 16'h3011); load(12'h002, 16'h2012);
      load(12'h003, 16'h4012); load(12'h004, 16'hB020); load(12'h020, 16'h1013);
      load(12'h021, 16'hB030); load(12'h022, 16'hF000);
      load(12'h010, 16'h0005); load(12'h011, 16'h0003); load(12'h012, 16'h0000);
      load(12'h013, 16'h8001);
      for (int i = 0; i < 20 && !m_halt; i++) model_step();
      base = fetch_log.size();
      start_run();
      run_trace();
      check_lit("load-acc-write-cycle", first_ld, 9);
      check_lit("count-after-load", cnt_after_ld, 1);
      check_lit("taken-jumps", jumps, 1);
      check_lit("stored-word", 32'(dmem[12'h012]), 32'h8);
      check_lit("final-acc", 32'(acc), 32'h8001);
      check_lit("halt-count", 32'(instr_count), 8);
      check_lit("halted", 32'(halted), 1);
      check_lit("not-illegal", 32'(illegal), 0);
      fexp = '{12'h000, 12'h001, 12'h002, 12'h003, 12'h004, 12'h020, 12'h021, 12'h022};
      check_lit("fetch-count", fetch_log.size() - base, 8);
      for (int i = 0; i < 8; i++)
         if (base + i < fetch_log.size())
            check_lit("fetch-addr", 32'(fetch_log[base + i]), 32'(fexp[i]));
      // HALTED is absorbing; start is held high throughout.
      push_none(6);
      start = 1'b1;
      run_trace();
      start = 1'b0;
      check_lit("halt-count-after-start", 32'(instr_count), 8);

      // Illegal opcode after a NOP.
      begin_scenario(16'h0);
      load(12'h000, 16'h0000); load(12'h001, 16'hE000);
      for (int i = 0; i < 5 && !m_halt; i++) model_step();
      push_none(3);
      start_run();
      start = 1'b1;
      run_trace();
      start = 1'b0;
      check_lit("ill-illegal", 32'(illegal), 1);
      check_lit("ill-halted", 32'(halted), 1);
      check_lit("ill-count", 32'(instr_count), 1);

      // Reset held three cycles from inside E_WRITE.
      begin_scenario(16'h5555);
      load(12'h000, 16'h0000); load(12'h001, 16'h2800); load(12'h800, 16'h1234);
      start_run();
      checking = 1'b0;
      g = 0;
      while (!mem_write && g < 60) begin
         @(posedge clock); #1;
         g++;
      end
      check_lit("reach-e-write", 32'(mem_write), 1);
      reset = 1'b1;
      #1 check_lit("reset-mem-write", 32'(mem_write), 0);
      repeat (3) begin
         @(negedge clock);
         check_lit("reset-controls", {pc_write, pc_src, mar_write, mar_src, mbr_write, mbr_src,
                                      ir_write, acc_write, acc_src, alu_op, mem_write}, 0);
      end
      @(posedge clock); #1 reset = 1'b0;
      check_lit("reset-state", 32'(state_out), 0);
      check_lit("reset-count", 32'(instr_count), 0);
      check_lit("reset-halted", 32'(halted), 0);
      check_lit("aborted-write", 32'(dmem[12'h800]), 32'h1234);

      // Randomized programs over opcodes 0..D.
      for (int s = 0; s < 3; s++) begin
         begin_scenario(16'($urandom));
         for (int i = 0; i < 256; i++) begin
            rop = 4'($urandom_range(0, 13));
            if (rop inside {4'hA, 4'hB, 4'hC})
               load(12'(i), {rop, 12'($urandom_range(0, 255))});
            else
               load(12'(i), {rop, 4'h8, 8'($urandom_range(0, 255))});
         end
         for (int i = 0; i < 256; i++)
            load(12'h800 + 12'(i), ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom));
         for (int i = 0; i < 40; i++) model_step();
         start_run();
         run_trace();
         check_lit("rand-acc", 32'(acc), 32'(m_acc));
         diff = 0;
         for (int i = 0; i < 256; i++) begin
            ad = 12'h800 + 12'(i);
            if (dmem[ad] !== mmem[ad]) diff++;
         end
         check_lit("rand-data-mem", diff, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
